// File: rtl/im2col_pipe_sched.sv
// -----------------------------------------------------------------------------
// im2col_pipe_sched
//
// Round-robin scheduler sharing one fixed-latency, free-running datapath
// between NUM_REQ requesters. At most one request is granted per cycle. The
// requester ID of every in-flight item rides on a delay line aligned with the
// datapath. Results are collected in a small output FIFO. Issue is
// credit-gated, so a result is never dropped when the consumer stalls.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-requester handshake (ready one-hot or zero)
//   req_data_i            packed request words, requester i at [i*WIDTH +: WIDTH]
//   pipe_valid_o/data_o   word issued into the datapath this cycle
//   pipe_res_i            datapath output, valid LATENCY cycles after issue
//   rsp_valid_o/ready_i   result FIFO head handshake
//   rsp_data_o, rsp_id_o  result word and originating requester at FIFO head
//   busy_o                items in flight or buffered
// -----------------------------------------------------------------------------
module im2col_pipe_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LATENCY    = 3,
  parameter int unsigned FIFO_DEPTH = 5,
  parameter int unsigned IDW        = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic                     pipe_valid_o,
  output logic [WIDTH-1:0]         pipe_data_o,
  input  logic [WIDTH-1:0]         pipe_res_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [WIDTH-1:0]         rsp_data_o,
  output logic [IDW-1:0]           rsp_id_o,
  output logic                     busy_o
);

  localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Wide enough to hold inflight + count without wrapping.
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic [IDW-1:0]   rr_q;
  logic [LATENCY-1:0] dl_valid_q;
  logic [IDW-1:0]   dl_id_q [LATENCY];

  logic [WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [IDW-1:0]   fifo_id_q   [FIFO_DEPTH];
  logic [PTRW-1:0]  rd_ptr_q;
  logic [PTRW-1:0]  wr_ptr_q;
  logic [CNTW-1:0]  count_q;

  logic [CNTW-1:0]  inflight;
  logic             issue_ok;
  logic             grant_found;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   cand;
  logic             issue;
  logic             push;
  logic             pop;

  function automatic logic [PTRW-1:0] ptr_next(input logic [PTRW-1:0] p);
    return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Credit: every item in the delay line already owns a FIFO slot. A pop in
  // this cycle is deliberately not counted, which keeps rsp_ready_i out of the
  // request-ready path. Reset also blocks issue so outputs go quiet at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight = '0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      inflight = inflight + CNTW'(dl_valid_q[k]);
    end
  end

  assign issue_ok = rst_ni && ((inflight + count_q) < CNTW'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Round-robin search starting at rr_q, wrapping at NUM_REQ.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign issue = issue_ok && grant_found;

  always_comb begin
    req_ready_o  = '0;
    pipe_valid_o = 1'b0;
    pipe_data_o  = '0;
    if (issue) begin
      req_ready_o[grant] = 1'b1;
      pipe_valid_o       = 1'b1;
      pipe_data_o        = req_data_i[grant*WIDTH +: WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (issue) begin
      rr_q <= (grant == IDW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ID delay line, aligned with the datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dl_valid_q <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) begin
        dl_id_q[k] <= '0;
      end
    end else begin
      dl_valid_q[0] <= issue;
      dl_id_q[0]    <= grant;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        dl_valid_q[k] <= dl_valid_q[k-1];
        dl_id_q[k]    <= dl_id_q[k-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  assign push        = dl_valid_q[LATENCY-1];
  assign rsp_valid_o = (count_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_data_q[k] <= '0;
        fifo_id_q[k]   <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= pipe_res_i;
        fifo_id_q[wr_ptr_q]   <= dl_id_q[LATENCY-1];
        wr_ptr_q              <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rsp_data_o = fifo_data_q[rd_ptr_q];
  assign rsp_id_o   = fifo_id_q[rd_ptr_q];
  assign busy_o     = (inflight != '0) || rsp_valid_o;

`ifndef SYNTHESIS
  // The credit scheme makes a push into a full FIFO impossible.
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && (count_q == CNTW'(FIFO_DEPTH))));

  grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  grant_is_requested: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((req_ready_o & ~req_valid_i) == '0));
`endif

endmodule

// File: tb/tb_im2col_pipe_sched.sv
// -----------------------------------------------------------------------------
// Testbench for im2col_pipe_sched: directed table, hand-written corner
// sequences (backpressure, reset mid-flight) and a long random run checked
// against a cycle-level reference model.
// -----------------------------------------------------------------------------
module tb_im2col_pipe_sched;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned WIDTH      = 32;
  localparam int unsigned LATENCY    = 3;
  localparam int unsigned FIFO_DEPTH = 5;
  localparam int unsigned IDW        = 2;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     pipe_valid;
  logic [WIDTH-1:0]         pipe_data;
  logic [WIDTH-1:0]         pipe_res;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [IDW-1:0]           rsp_id;
  logic                     busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  im2col_pipe_sched #(
    .NUM_REQ   (NUM_REQ),
    .WIDTH     (WIDTH),
    .LATENCY   (LATENCY),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .pipe_valid_o(pipe_valid),
    .pipe_data_o (pipe_data),
    .pipe_res_i  (pipe_res),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id),
    .busy_o      (busy)
  );

  // Datapath stand-in: LATENCY free-running registers computing f(x).
  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  logic [WIDTH-1:0] dp [LATENCY];
  always @(posedge clk) begin
    dp[0] <= f(pipe_data);
    for (int k = 1; k < LATENCY; k++) dp[k] <= dp[k-1];
  end
  assign pipe_res = dp[LATENCY-1];

  // Fixed request words for the directed part.
  function automatic logic [WIDTH-1:0] dval(input int unsigned id);
    case (id)
      0:       return 32'hCAFE_0000;
      1:       return 32'h1111_2222;
      2:       return 32'h0000_00A5;
      default: return 32'hD3D3_0003;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int unsigned      id;
  } ent_t;

  int unsigned      m_rr;
  bit               m_dv [LATENCY];
  int unsigned      m_did[LATENCY];
  logic [WIDTH-1:0] m_dd [LATENCY];
  ent_t             m_q[$];
  bit               m_issue;
  int unsigned      m_g;
  logic [WIDTH-1:0] m_pd;
  bit               m_pop;

  task automatic model_clear();
    m_rr = 0;
    for (int k = 0; k < LATENCY; k++) begin
      m_dv[k] = 1'b0; m_did[k] = 0; m_dd[k] = '0;
    end
    m_q.delete();
    m_issue = 1'b0; m_g = 0; m_pd = '0; m_pop = 1'b0;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %h required %h", name, $time, act, exp);
    end
  endtask

  // Apply inputs at the falling edge, then compare against the model.
  task automatic drive(input logic [NUM_REQ-1:0] v, input logic r);
    int unsigned infl;
    int unsigned idx;
    bit found;
    logic [NUM_REQ-1:0] er;
    @(negedge clk);
    req_valid = v;
    rsp_ready = r;
    #1;
    infl = 0;
    for (int k = 0; k < LATENCY; k++) infl += m_dv[k] ? 1 : 0;
    found = 1'b0;
    m_g   = 0;
    if (infl + m_q.size() < FIFO_DEPTH) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (m_rr + k) % NUM_REQ;
        if (!found && v[idx]) begin
          found = 1'b1;
          m_g   = idx;
        end
      end
    end
    m_issue = found;
    er   = found ? (NUM_REQ'(1) << m_g) : '0;
    m_pd = found ? req_data[m_g*WIDTH +: WIDTH] : '0;
    chk("req_ready", WIDTH'(req_ready), WIDTH'(er));
    chk("pipe_valid", WIDTH'(pipe_valid), WIDTH'(found));
    chk("pipe_data", pipe_data, m_pd);
    chk("rsp_valid", WIDTH'(rsp_valid), WIDTH'(m_q.size() != 0));
    chk("busy", WIDTH'(busy), WIDTH'((infl != 0) || (m_q.size() != 0)));
    if (m_q.size() != 0) begin
      chk("rsp_data", rsp_data, m_q[0].data);
      chk("rsp_id", WIDTH'(rsp_id), WIDTH'(m_q[0].id));
    end
    m_pop = (m_q.size() != 0) && r;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    if (m_pop) e = m_q.pop_front();
    if (m_dv[LATENCY-1]) begin
      e.data = m_dd[LATENCY-1];
      e.id   = m_did[LATENCY-1];
      m_q.push_back(e);
    end
    for (int k = LATENCY - 1; k > 0; k--) begin
      m_dv[k] = m_dv[k-1]; m_did[k] = m_did[k-1]; m_dd[k] = m_dd[k-1];
    end
    m_dv[0]  = m_issue;
    m_did[0] = m_g;
    m_dd[0]  = f(m_pd);
    if (m_issue) m_rr = (m_g + 1) % NUM_REQ;
    #1;
  endtask

  // Assert reset right now, check outputs go quiet, release at next fall.
  task automatic reset_now(input string tag);
    rst_ni = 1'b0;
    #1;
    chk({tag, "_req_ready"}, WIDTH'(req_ready), '0);
    chk({tag, "_pipe_valid"}, WIDTH'(pipe_valid), '0);
    chk({tag, "_pipe_data"}, pipe_data, '0);
    chk({tag, "_rsp_valid"}, WIDTH'(rsp_valid), '0);
    chk({tag, "_rsp_data"}, rsp_data, '0);
    chk({tag, "_rsp_id"}, WIDTH'(rsp_id), '0);
    chk({tag, "_busy"}, WIDTH'(busy), '0);
    req_valid = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    model_clear();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_now("rst");
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit                 rst;
    logic [NUM_REQ-1:0] v;
    logic               r;
    logic [NUM_REQ-1:0] er;
    logic               erv;
    int unsigned        eid;
    logic               ebusy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit rst, input logic [3:0] v, input logic r,
                     input logic [3:0] er, input logic erv,
                     input int unsigned eid, input logic ebusy);
    vec_t t;
    t.rst = rst; t.v = v; t.r = r; t.er = er;
    t.erv = erv; t.eid = eid; t.ebusy = ebusy;
    tbl.push_back(t);
  endtask

  logic [NUM_REQ-1:0] rv;
  int unsigned        acc;

  initial begin
    rst_ni    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*WIDTH +: WIDTH] = dval(i);
    model_clear();

    // Single request from requester 2: response LATENCY+1 cycles later.
    add(1, 4'b0100, 1, 4'b0100, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
    // Fairness: all valid, back-to-back grants and gapless responses.
    add(1, 4'b1111, 1, 4'b0001, 0, 0, 0);
    add(0, 4'b1111, 1, 4'b0010, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0100, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b1000, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0001, 1, 0, 1);
    add(0, 4'b1111, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b1111, 1, 4'b0100, 1, 2, 1);
    add(0, 4'b1111, 1, 4'b1000, 1, 3, 1);
    add(0, 4'b1111, 1, 4'b0001, 1, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
    // Wrap/rotation: grant 1 (rr->2), then {3,1} gives 3, then 1, then rr=2.
    add(1, 4'b0010, 1, 4'b0010, 0, 0, 0);
    add(0, 4'b1010, 1, 4'b1000, 0, 0, 1);
    add(0, 4'b0010, 1, 4'b0010, 0, 0, 1);
    add(0, 4'b1110, 1, 4'b0100, 0, 0, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 3, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 1, 1);
    add(0, 4'b0000, 1, 4'b0000, 1, 2, 1);
    add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

    foreach (tbl[n]) begin
      if (tbl[n].rst) apply_reset();
      drive(tbl[n].v, tbl[n].r);
      chk("tbl_ready", WIDTH'(req_ready), WIDTH'(tbl[n].er));
      chk("tbl_rsp_valid", WIDTH'(rsp_valid), WIDTH'(tbl[n].erv));
      chk("tbl_busy", WIDTH'(busy), WIDTH'(tbl[n].ebusy));
      if (tbl[n].erv) begin
        chk("tbl_rsp_id", WIDTH'(rsp_id), WIDTH'(tbl[n].eid));
        chk("tbl_rsp_data", rsp_data, f(dval(tbl[n].eid)));
      end
      tick();
    end

    // Backpressure: exactly FIFO_DEPTH accepts, then stall until a pop.
    apply_reset();
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      drive(4'b1111, 1'b0);
      if (req_ready != '0) acc++;
      if (c >= FIFO_DEPTH) chk("bp_stall", WIDTH'(req_ready), '0);
      tick();
    end
    chk("bp_accepts", acc, FIFO_DEPTH);
    drive(4'b1111, 1'b1);
    chk("bp_no_issue_on_pop", WIDTH'(req_ready), '0);
    chk("bp_first_id", WIDTH'(rsp_id), 0);
    tick();
    drive(4'b1111, 1'b1);
    chk("bp_resume", WIDTH'(req_ready), WIDTH'(4'b0010));
    chk("bp_second_id", WIDTH'(rsp_id), 1);
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(4'b0000, 1'b1);
      tick();
    end
    chk("bp_drained", WIDTH'(busy), '0);

    // Reset mid-flight: 3 in flight + 2 buffered, then reset.
    apply_reset();
    for (int c = 0; c < FIFO_DEPTH; c++) begin
      drive(4'b1111, 1'b0);
      tick();
    end
    drive(4'b1111, 1'b0);
    chk("mid_busy", WIDTH'(busy), 1);
    chk("mid_rsp_valid", WIDTH'(rsp_valid), 1);
    reset_now("mid_rst");
    drive(4'b0010, 1'b1);
    chk("post_rst_ready", WIDTH'(req_ready), WIDTH'(4'b0010));
    tick();
    for (int c = 0; c < LATENCY; c++) begin
      drive(4'b0000, 1'b1);
      chk("post_rst_no_stale", WIDTH'(rsp_valid), '0);
      tick();
    end
    drive(4'b0000, 1'b1);
    chk("post_rst_rsp_valid", WIDTH'(rsp_valid), 1);
    chk("post_rst_rsp_id", WIDTH'(rsp_id), 1);
    chk("post_rst_rsp_data", rsp_data, f(dval(1)));
    tick();

    // Random traffic against the model; requesters hold valid/data until
    // accepted.
    apply_reset();
    rv = '0;
    for (int c = 0; c < 10000; c++) begin
      drive(rv, ($urandom_range(0, 3) != 0));
      tick();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_issue && (m_g == i)) begin
          rv[i] = 1'($urandom_range(0, 1));
          req_data[i*WIDTH +: WIDTH] = $urandom();
        end else if (!rv[i]) begin
          rv[i] = 1'($urandom_range(0, 1));
          if (rv[i]) req_data[i*WIDTH +: WIDTH] = $urandom();
        end
      end
    end
    for (int c = 0; c < 20; c++) begin
      drive('0, 1'b1);
      tick();
    end
    chk("final_idle", WIDTH'(busy), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
